// File: rtl/mor1kx_pic_pkg.sv
// Shared constants for the vectored PIC: SPR group/offsets, ID width, PICVR layout.
// Optional synchroniser is selected with the MOR1KX_PIC_SYNC_EN macro in mor1kx_pic_vec.
package mor1kx_pic_pkg;

   localparam int PIC_ID_W = 5;

   localparam logic [4:0]  SPR_GRP_PIC = 5'd9;
   localparam logic [10:0] OFS_PICMR   = 11'd0;
   localparam logic [10:0] OFS_PICSR   = 11'd2;
   localparam logic [10:0] OFS_PICTR   = 11'd4;
   localparam logic [10:0] OFS_PICVR   = 11'd5;

   localparam int PICVR_IRQ_BIT = 31;
   localparam int PICVR_ID_LSB  = 0;

   // Mask with the n lowest bits set; n may be 0..32.
   function automatic logic [31:0] low_ones(input int n);
      logic [31:0] m;
      for (int i = 0; i < 32; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/mor1kx_pic_vec_if.sv
// SPR bus bundle between the CPU SPR interconnect (master) and the PIC (slave).
interface mor1kx_pic_vec_if;
   logic        spr_access_i;
   logic        spr_we_i;
   logic [15:0] spr_addr_i;
   logic [31:0] spr_dat_i;
   logic        spr_bus_ack;
   logic [31:0] spr_dat_o;

   modport master (
      output spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
      input  spr_bus_ack, spr_dat_o
   );

   modport slave (
      input  spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
      output spr_bus_ack, spr_dat_o
   );
endinterface

// File: rtl/mor1kx_pic_prienc.sv
// Combinational lowest-index-first priority encoder: {any, id} of a pending vector.
module mor1kx_pic_prienc
   import mor1kx_pic_pkg::*;
#(
   parameter int NUM_IRQ = 32
) (
   input  logic [NUM_IRQ-1:0]  vec_i,
   output logic                any_o,
   output logic [PIC_ID_W-1:0] id_o
);

   always_comb begin
      any_o = |vec_i;
      id_o  = '0;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            id_o = PIC_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/mor1kx_pic_vec.sv
// Vectored PIC for mor1kx: NUM_IRQ lines, per-line level/edge trigger, registered encoder.
// Define MOR1KX_PIC_SYNC_EN to pass irq_i through a 2-flop synchroniser before masking.
module mor1kx_pic_vec
   import mor1kx_pic_pkg::*;
#(
   parameter int          NUM_IRQ       = 32,
   parameter int          NMI_WIDTH     = 0,
   parameter logic [31:0] TRIGGER_RESET = 32'h0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_IRQ-1:0]  irq_i,
   output logic                irq_o,
   output logic [PIC_ID_W-1:0] irq_id_o,
   output logic [31:0]         spr_picmr_o,
   output logic [31:0]         spr_picsr_o,
   mor1kx_pic_vec_if.slave     spr
);

   localparam logic [31:0] IRQ_MASK = low_ones(NUM_IRQ);
   localparam logic [31:0] NMI_MASK = low_ones(NMI_WIDTH) & IRQ_MASK;

   logic [31:0] picmr_q, picmr_d;
   logic [31:0] picsr_q, picsr_d;
   logic [31:0] pictr_q, pictr_d;
   logic [31:0] irq_prev_q, irq_prev_d;
   logic        irq_o_q, irq_o_d;
   logic [PIC_ID_W-1:0] irq_id_q, irq_id_d;

   logic [31:0] irq_ext, irq_s, unmasked, edges, clr;
   logic        grp_sel, wr_picmr, wr_picsr, wr_pictr;
   logic [10:0] ofs;
   logic        enc_any;
   logic [PIC_ID_W-1:0] enc_id;

   always_comb begin
      irq_ext              = '0;
      irq_ext[NUM_IRQ-1:0] = irq_i;
   end

`ifdef MOR1KX_PIC_SYNC_EN
   logic [31:0] sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = irq_ext;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_ext;
`endif

   assign ofs      = spr.spr_addr_i[10:0];
   assign grp_sel  = spr.spr_access_i && (spr.spr_addr_i[15:11] == SPR_GRP_PIC);
   assign wr_picmr = grp_sel && spr.spr_we_i && (ofs == OFS_PICMR);
   assign wr_picsr = grp_sel && spr.spr_we_i && (ofs == OFS_PICSR);
   assign wr_pictr = grp_sel && spr.spr_we_i && (ofs == OFS_PICTR);

   assign unmasked = picmr_q & irq_s;
   assign edges    = unmasked & ~irq_prev_q;
   assign clr      = wr_picsr ? spr.spr_dat_i : 32'h0;

   always_comb begin
      picmr_d    = wr_picmr ? ((spr.spr_dat_i & IRQ_MASK) | NMI_MASK) : picmr_q;
      pictr_d    = wr_pictr ? (spr.spr_dat_i & IRQ_MASK) : pictr_q;
      irq_prev_d = unmasked;
      // Edge lines: sticky with W1C, a same-cycle edge beats the clear. Level lines track.
      picsr_d    = ((pictr_q & ((picsr_q & ~clr) | edges)) |
                    (~pictr_q & unmasked)) & IRQ_MASK;
      irq_o_d    = enc_any;
      irq_id_d   = enc_id;
   end

   mor1kx_pic_prienc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prienc (
      .vec_i (picsr_q[NUM_IRQ-1:0]),
      .any_o (enc_any),
      .id_o  (enc_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         picmr_q    <= NMI_MASK;
         picsr_q    <= '0;
         pictr_q    <= TRIGGER_RESET & IRQ_MASK;
         irq_prev_q <= '0;
         irq_o_q    <= 1'b0;
         irq_id_q   <= '0;
      end else begin
         picmr_q    <= picmr_d;
         picsr_q    <= picsr_d;
         pictr_q    <= pictr_d;
         irq_prev_q <= irq_prev_d;
         irq_o_q    <= irq_o_d;
         irq_id_q   <= irq_id_d;
      end
   end

   always_comb begin
      spr.spr_dat_o = '0;
      if (grp_sel) begin
         case (ofs)
            OFS_PICMR: spr.spr_dat_o = picmr_q;
            OFS_PICSR: spr.spr_dat_o = picsr_q;
            OFS_PICTR: spr.spr_dat_o = pictr_q;
            OFS_PICVR: begin
               spr.spr_dat_o[PICVR_IRQ_BIT]                 = irq_o_q;
               spr.spr_dat_o[PICVR_ID_LSB +: PIC_ID_W]      = irq_id_q;
            end
            default:   spr.spr_dat_o = '0;
         endcase
      end
   end

   assign spr.spr_bus_ack = spr.spr_access_i;
   assign irq_o           = irq_o_q;
   assign irq_id_o        = irq_id_q;
   assign spr_picmr_o     = picmr_q;
   assign spr_picsr_o     = picsr_q;

endmodule

// File: tb/tb_mor1kx_pic_vec.sv
// Directed bench for mor1kx_pic_vec: a 32-line instance with 2 NMI lines and an 8-line instance.
module tb_mor1kx_pic_vec;

`ifdef MOR1KX_PIC_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   localparam logic [15:0] A_PICMR = 16'h4800;
   localparam logic [15:0] A_PICSR = 16'h4802;
   localparam logic [15:0] A_PICTR = 16'h4804;
   localparam logic [15:0] A_PICVR = 16'h4805;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] irq = '0;
   logic [7:0]  irq_n = '0;

   logic        irq_o, irq_o_n;
   logic [4:0]  irq_id, irq_id_n;
   logic [31:0] picmr, picsr, picmr_n, picsr_n;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   mor1kx_pic_vec_if bus ();
   mor1kx_pic_vec_if bus_n ();

   mor1kx_pic_vec #(
      .NUM_IRQ(32), .NMI_WIDTH(2), .TRIGGER_RESET(32'h0000_0001)
   ) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_o(irq_o), .irq_id_o(irq_id),
      .spr_picmr_o(picmr), .spr_picsr_o(picsr), .spr(bus)
   );

   mor1kx_pic_vec #(
      .NUM_IRQ(8), .NMI_WIDTH(0), .TRIGGER_RESET(32'h0000_1F0F)
   ) dut_n (
      .clk(clk), .rst_n(rst_n), .irq_i(irq_n), .irq_o(irq_o_n), .irq_id_o(irq_id_n),
      .spr_picmr_o(picmr_n), .spr_picsr_o(picsr_n), .spr(bus_n)
   );

   typedef struct {
      logic        we;
      logic [15:0] waddr;
      logic [31:0] wdat;
      logic [15:0] raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic spr_wr(input bit nar, input logic [15:0] a, input logic [31:0] d);
      if (nar) begin
         bus_n.spr_access_i = 1'b1; bus_n.spr_we_i = 1'b1;
         bus_n.spr_addr_i = a; bus_n.spr_dat_i = d;
      end else begin
         bus.spr_access_i = 1'b1; bus.spr_we_i = 1'b1;
         bus.spr_addr_i = a; bus.spr_dat_i = d;
      end
      @(negedge clk);
      bus.spr_access_i = 1'b0; bus.spr_we_i = 1'b0;
      bus_n.spr_access_i = 1'b0; bus_n.spr_we_i = 1'b0;
   endtask

   task automatic spr_rd(input bit nar, input logic [15:0] a, output logic [31:0] d);
      if (nar) begin
         bus_n.spr_access_i = 1'b1; bus_n.spr_we_i = 1'b0; bus_n.spr_addr_i = a;
      end else begin
         bus.spr_access_i = 1'b1; bus.spr_we_i = 1'b0; bus.spr_addr_i = a;
      end
      #1;
      d = nar ? bus_n.spr_dat_o : bus.spr_dat_o;
      bus.spr_access_i = 1'b0;
      bus_n.spr_access_i = 1'b0;
   endtask

   // Raw irq change, then let the synchroniser (if any) catch up.
   task automatic set_irq(input logic [31:0] v);
      irq = v;
      repeat (SL) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;

      bus.spr_access_i = 1'b0; bus.spr_we_i = 1'b0; bus.spr_addr_i = '0; bus.spr_dat_i = '0;
      bus_n.spr_access_i = 1'b0; bus_n.spr_we_i = 1'b0; bus_n.spr_addr_i = '0; bus_n.spr_dat_i = '0;

      tbl[0] = '{1'b1, A_PICMR, 32'h0000_0000, A_PICMR, 32'h0000_0003};
      tbl[1] = '{1'b1, A_PICMR, 32'hF0F0_0000, A_PICMR, 32'hF0F0_0003};
      tbl[2] = '{1'b1, A_PICTR, 32'hA5A5_5A5A, A_PICTR, 32'hA5A5_5A5A};
      tbl[3] = '{1'b1, A_PICVR, 32'hFFFF_FFFF, A_PICVR, 32'h0000_0000};
      tbl[4] = '{1'b1, A_PICSR, 32'hFFFF_FFFF, A_PICSR, 32'h0000_0000};
      tbl[5] = '{1'b0, 16'h0000, 32'h0,        16'h4801, 32'h0000_0000};
      tbl[6] = '{1'b0, 16'h0000, 32'h0,        16'h4803, 32'h0000_0000};
      tbl[7] = '{1'b0, 16'h0000, 32'h0,        16'h0000, 32'h0000_0000};
      tbl[8] = '{1'b1, 16'h0004, 32'h0,        A_PICTR, 32'hA5A5_5A5A};
      tbl[9] = '{1'b1, A_PICMR, 32'h0000_0000, A_PICMR, 32'h0000_0003};

      // Reset state
      repeat (2) step();
      rst_n = 1'b1;
      chk("rst_irq_o", {31'b0, irq_o}, 32'h0);
      chk("rst_irq_id", {27'b0, irq_id}, 32'h0);
      chk("rst_picsr", picsr, 32'h0);
      chk("rst_picmr", picmr, 32'h3);
      spr_rd(0, A_PICTR, rd); chk("rst_pictr", rd, 32'h1);
      chk("rst_picmr_n", picmr_n, 32'h0);
      spr_rd(1, A_PICTR, rd); chk("rst_pictr_n", rd, 32'h0F);

      // Register access table
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) spr_wr(0, tbl[i].waddr, tbl[i].wdat);
         spr_rd(0, tbl[i].raddr, rd);
         $display("vec %0d: we=%0b waddr=%h wdat=%h raddr=%h rd=%h exp=%h",
                  i, tbl[i].we, tbl[i].waddr, tbl[i].wdat, tbl[i].raddr, rd, tbl[i].exp);
         chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end
      bus.spr_access_i = 1'b1; bus.spr_addr_i = 16'h1234; #1;
      chk("bus_ack", {31'b0, bus.spr_bus_ack}, 32'h1);
      bus.spr_access_i = 1'b0; #1;
      chk("bus_ack_idle", {31'b0, bus.spr_bus_ack}, 32'h0);
      step();

      // Level line 3
      spr_wr(0, A_PICTR, 32'h0);
      spr_wr(0, A_PICMR, 32'h8);
      chk("lvl_picmr", picmr, 32'hB);
      set_irq(32'h8);
      step();
      chk("lvl_picsr_k", picsr, 32'h8);
      chk("lvl_irq_o_k", {31'b0, irq_o}, 32'h0);
      step();
      chk("lvl_irq_o_k1", {31'b0, irq_o}, 32'h1);
      chk("lvl_id_k1", {27'b0, irq_id}, 32'h3);
      spr_wr(0, A_PICSR, 32'h8);
      chk("lvl_w1c_ignored", picsr, 32'h8);
      set_irq(32'h0);
      step();
      chk("lvl_drop_1", {31'b0, irq_o}, 32'h1);
      step();
      chk("lvl_drop_2", {31'b0, irq_o}, 32'h0);

      // Edge line 5
      spr_wr(0, A_PICTR, 32'h20);
      spr_wr(0, A_PICMR, 32'h20);
      set_irq(32'h20);
      step();
      set_irq(32'h0);
      step();
      chk("edge_sticky", picsr, 32'h20);
      chk("edge_irq_o", {31'b0, irq_o}, 32'h1);
      spr_wr(0, A_PICSR, 32'h20);
      chk("edge_clr_picsr", picsr, 32'h0);
      chk("edge_clr_irq_o_k", {31'b0, irq_o}, 32'h1);
      step();
      chk("edge_clr_irq_o_k1", {31'b0, irq_o}, 32'h0);
      set_irq(32'h20);
      step();
      set_irq(32'h0);
      step();
      chk("edge_relatch", picsr, 32'h20);
      set_irq(32'h20);
      spr_wr(0, A_PICSR, 32'h20);
      chk("edge_set_wins", picsr, 32'h20);
      spr_wr(0, A_PICSR, 32'h20);
      step();
      chk("edge_held_no_reset", picsr, 32'h0);
      set_irq(32'h0);
      step();

      // Priority between edge lines 2 and 7
      spr_wr(0, A_PICTR, 32'h84);
      spr_wr(0, A_PICMR, 32'h84);
      set_irq(32'h84);
      step();
      step();
      chk("pri_id2", {27'b0, irq_id}, 32'h2);
      spr_rd(0, A_PICVR, rd); chk("pri_picvr2", rd, 32'h8000_0002);
      spr_wr(0, A_PICSR, 32'h4);
      chk("pri_picsr", picsr, 32'h80);
      step();
      chk("pri_id7", {27'b0, irq_id}, 32'h7);
      spr_rd(0, A_PICVR, rd); chk("pri_picvr7", rd, 32'h8000_0007);
      set_irq(32'h0);
      spr_wr(0, A_PICSR, 32'h80);
      step();
      chk("pri_idle_irq_o", {31'b0, irq_o}, 32'h0);
      chk("pri_idle_id", {27'b0, irq_id}, 32'h0);

      // NMI line 1 with PICMR written to 0
      spr_wr(0, A_PICTR, 32'h0);
      spr_wr(0, A_PICMR, 32'h0);
      spr_rd(0, A_PICMR, rd); chk("nmi_picmr", rd, 32'h3);
      set_irq(32'h2);
      step();
      chk("nmi_picsr", picsr, 32'h2);
      set_irq(32'h0);
      step();
      chk("nmi_drop", picsr, 32'h0);
      step();

      // Mode switching on line 4
      spr_wr(0, A_PICMR, 32'h10);
      set_irq(32'h10);
      step();
      chk("mode_lvl", picsr, 32'h10);
      spr_wr(0, A_PICTR, 32'h10);
      set_irq(32'h0);
      step();
      chk("mode_l2e_keeps", picsr, 32'h10);
      spr_wr(0, A_PICTR, 32'h0);
      step();
      chk("mode_e2l_follows", picsr, 32'h0);
      step();

      // Masking an already-set edge line
      spr_wr(0, A_PICTR, 32'h20);
      spr_wr(0, A_PICMR, 32'h20);
      set_irq(32'h20);
      step();
      spr_wr(0, A_PICMR, 32'h0);
      chk("mask_keeps_set", picsr, 32'h20);
      set_irq(32'h0);
      spr_wr(0, A_PICSR, 32'h20);
      set_irq(32'h20);
      step();
      step();
      chk("mask_blocks_new", picsr, 32'h0);
      set_irq(32'h0);
      step();

      // Narrow 8-line build
      spr_wr(1, A_PICMR, 32'hFFFF_FFFF);
      spr_wr(1, A_PICTR, 32'hFFFF_FFFF);
      spr_rd(1, A_PICMR, rd); chk("nar_picmr", rd, 32'hFF);
      spr_rd(1, A_PICTR, rd); chk("nar_pictr", rd, 32'hFF);
      irq_n = 8'h81;
      repeat (SL) step();
      step();
      chk("nar_picsr", picsr_n, 32'h81);
      step();
      chk("nar_irq_o", {31'b0, irq_o_n}, 32'h1);
      chk("nar_id", {27'b0, irq_id_n}, 32'h0);
      spr_wr(1, A_PICSR, 32'hFFFF_FFFF);
      spr_rd(1, A_PICSR, rd); chk("nar_clr", rd, 32'h0);
      irq_n = 8'h0;
      step();

      // Reset mid-operation with NMI lines 0 (edge after reset) and 1 (level)
      spr_wr(0, A_PICTR, 32'h0);
      set_irq(32'h3);
      step();
      step();
      chk("mid_irq_o_pre", {31'b0, irq_o}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_irq_o", {31'b0, irq_o}, 32'h0);
      chk("mid_rst_id", {27'b0, irq_id}, 32'h0);
      chk("mid_rst_picsr", picsr, 32'h0);
      step();
      rst_n = 1'b1;
      repeat (SL) step();
      step();
      chk("mid_relatch", picsr, 32'h3);
      step();
      chk("mid_irq_o_post", {31'b0, irq_o}, 32'h1);
      set_irq(32'h0);
      step();
      chk("mid_edge_kept_level_drop", picsr, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
